// File: rtl/dm_access_unit.sv
// Data-memory access unit: turns M-stage load/store requests into single bus
// transactions with byte lanes, extends load results, checks alignment and
// bounds each bus access with a timeout that raises a bus-error exception.
module dm_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             exc_valid_q, exc_valid_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    // Request attributes needed only to shape the load result.
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;

    logic             misalign;

    // Byte enables for a store of the given size at byte offset off.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the significant low bits of the store value across all lanes.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Pick the addressed lane out of the bus word and sign/zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign misalign = (req_size == SZ_ILL)
                    | ((req_size == SZ_HALF) & req_addr[0])
                    | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

    assign req_ready  = (state_q == S_IDLE);
    assign stall      = (state_q == S_BUSY) | ((state_q == S_IDLE) & req_valid);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign exc_valid  = exc_valid_q;
    assign exc_code   = exc_code_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

    // Next-state and registered-output logic of the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        exc_valid_d  = 1'b0;
        exc_code_d   = EXC_NONE;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (misalign) begin
                        // Address error: report immediately, never touch the bus.
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        exc_valid_d  = 1'b1;
                        exc_code_d   = req_we ? EXC_ADES : EXC_ADEL;
                    end else begin
                        state_d     = S_BUSY;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_be_d    = req_we ? store_be(req_size, req_addr[1:0]) : 4'b1111;
                        bus_wdata_d = req_we ? store_data(req_size, req_wdata) : 32'd0;
                        size_d      = req_size;
                        uns_d       = req_unsigned;
                        off_d       = req_addr[1:0];
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // An ack on the final timeout cycle takes priority over the timeout.
                if (bus_ack) begin
                    state_d      = S_DONE;
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = bus_we_q ? 32'd0 : load_extract(bus_rdata, size_q, off_q, uns_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_DONE;
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'd0;
                    exc_valid_d  = 1'b1;
                    exc_code_d   = EXC_DBE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and every externally visible register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            exc_valid_q  <= 1'b0;
            exc_code_q   <= EXC_NONE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_be_q     <= 4'd0;
            bus_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            exc_valid_q  <= exc_valid_d;
            exc_code_q   <= exc_code_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    // Latched load-shaping attributes; only meaningful while an access is in flight.
    always_ff @(posedge clk) begin
        size_q <= size_d;
        uns_q  <= uns_d;
        off_q  <= off_d;
    end

endmodule
